// File: rtl/pp_gen_pkg.sv
// Shared constants and types for the partial-product generator and its skid buffer.
// Row widths, row offsets into the flattened dot vector, and the buffer sizing all live here.
package pp_gen_pkg;

    localparam int OP_W       = 8;
    localparam int N_COLS     = 2 * OP_W - 1;
    localparam int N_ROWS     = OP_W;
    localparam int N_DOTS     = OP_W * OP_W;
    localparam int ROW_W   [N_ROWS] = '{15, 13, 11, 9, 7, 5, 3, 1};
    localparam int ROW_OFS [N_ROWS] = '{0, 15, 28, 39, 48, 55, 60, 63};

    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operand_t;

    // Lowest multiplier bit that contributes to column c.
    function automatic int col_jmin(input int c);
        return (c > OP_W - 1) ? c - (OP_W - 1) : 0;
    endfunction

endpackage

// File: rtl/pp_gen_if.sv
// Operand-in / partial-products-out handshake bundle for pp_gen.
// master drives operands and pp_ready; slave (pp_gen) drives in_ready, pp_valid and the dot rows.
interface pp_gen_if;
    import pp_gen_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OP_W-1:0]      a;
    logic [OP_W-1:0]      b;
    logic                 pp_ready;
    logic                 pp_valid;
    logic [ROW_W[0]-1:0]  pp0;
    logic [ROW_W[1]-1:0]  pp1;
    logic [ROW_W[2]-1:0]  pp2;
    logic [ROW_W[3]-1:0]  pp3;
    logic [ROW_W[4]-1:0]  pp4;
    logic [ROW_W[5]-1:0]  pp5;
    logic [ROW_W[6]-1:0]  pp6;
    logic [ROW_W[7]-1:0]  pp7;

    modport master (
        output in_valid, a, b, pp_ready,
        input  in_ready, pp_valid, pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7
    );

    modport slave (
        input  in_valid, a, b, pp_ready,
        output in_ready, pp_valid, pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7
    );

endinterface

// File: rtl/pp_skid_fifo.sv
// Two-entry operand FIFO in front of the pp_gen output register.
// not_full is registered from the next-state occupancy so it matches the full flag cycle-exactly.
module pp_skid_fifo
    import pp_gen_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  operand_t push_data,
    input  logic     pop,
    output operand_t head,
    output logic     empty,
    output logic     not_full
);

    operand_t         mem_d [FIFO_DEPTH];
    operand_t         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [OCC_W-1:0] count_d, count_q;
    logic             not_full_d, not_full_q;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through this block infers a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
        not_full_d = (count_d != OCC_W'(FIFO_DEPTH));
    end

    // NOTE: storage has no reset; count_q guards every read, so stale entries are never consumed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            not_full_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign not_full = not_full_q;

endmodule

// File: rtl/pp_gen.sv
// 8x8 unsigned partial-product generator: skid-buffered operands, registered pair, dot rows for a Wallace tree.
// Optional build macro PP_GEN_HOLD_EN keeps the dot rows frozen while idle instead of forcing them to zero.
module pp_gen
    import pp_gen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    pp_gen_if.slave          bus,
    output logic [CNT_W-1:0] ops_count
);

    operand_t         in_op;
    operand_t         fifo_head;
    logic             fifo_empty;
    logic             fifo_not_full;
    logic             push;
    logic             pop;

    operand_t         op_d, op_q;
    logic             pp_valid_d, pp_valid_q;
    logic [CNT_W-1:0] ops_count_d, ops_count_q;

    wire  [N_DOTS-1:0] dots;
    logic [N_DOTS-1:0] pp_bits;

    assign in_op        = '{a: bus.a, b: bus.b};
    assign push         = bus.in_valid & fifo_not_full;
    assign pop          = ~fifo_empty & (~pp_valid_q | bus.pp_ready);
    assign bus.in_ready = fifo_not_full;

    pp_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_op),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .not_full  (fifo_not_full)
    );

    always_comb begin
        op_d        = op_q;
        pp_valid_d  = pp_valid_q;
        ops_count_d = ops_count_q;
        if (pop) begin
            op_d       = fifo_head;
            pp_valid_d = 1'b1;
        end else if (bus.pp_ready) begin
            pp_valid_d = 1'b0;
        end
        if (push && (ops_count_q != '1)) begin
            ops_count_d = ops_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            pp_valid_q  <= 1'b0;
            ops_count_q <= '0;
        end else begin
            op_q        <= op_d;
            pp_valid_q  <= pp_valid_d;
            ops_count_q <= ops_count_d;
        end
    end

    // Dots of column c stack by ascending multiplier bit; row r lands at bit c-r of its row.
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
        localparam int JMIN = col_jmin(c);
        for (genvar r = 0; r < N_ROWS; r++) begin : g_row
            if (r <= c && r <= N_COLS - 1 - c) begin : g_dot
                assign dots[ROW_OFS[r] + c - r] = op_q.a[c - JMIN - r] & op_q.b[JMIN + r];
            end
        end
    end

`ifdef PP_GEN_HOLD_EN
    assign pp_bits = dots;
`else
    assign pp_bits = pp_valid_q ? dots : '0;
`endif

    assign bus.pp0      = pp_bits[ROW_OFS[0] +: ROW_W[0]];
    assign bus.pp1      = pp_bits[ROW_OFS[1] +: ROW_W[1]];
    assign bus.pp2      = pp_bits[ROW_OFS[2] +: ROW_W[2]];
    assign bus.pp3      = pp_bits[ROW_OFS[3] +: ROW_W[3]];
    assign bus.pp4      = pp_bits[ROW_OFS[4] +: ROW_W[4]];
    assign bus.pp5      = pp_bits[ROW_OFS[5] +: ROW_W[5]];
    assign bus.pp6      = pp_bits[ROW_OFS[6] +: ROW_W[6]];
    assign bus.pp7      = pp_bits[ROW_OFS[7] +: ROW_W[7]];
    assign bus.pp_valid = pp_valid_q;
    assign ops_count    = ops_count_q;

endmodule

// File: tb/tb_pp_gen.sv
// Scoreboard bench for pp_gen: expected dot rows are queued on each accepted pair and
// popped by a negedge monitor whenever the DUT presents or hands off an output.
module tb_pp_gen;

    localparam int CNT_W   = 4;
    localparam int DEPTH   = 2;
    localparam int OPS_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] ops_count;

    pp_gen_if bus ();

    pp_gen #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ops_count (ops_count)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q [$];
    logic [63:0] last_exp = '0;
    int          m_cnt = 0;
    bit          m_valid = 0;
    int          m_ops = 0;
    bit          m_push, m_load;
    logic [63:0] idle_exp;

    wire [63:0] act_dots = {bus.pp7, bus.pp6, bus.pp5, bus.pp4,
                            bus.pp3, bus.pp2, bus.pp1, bus.pp0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every product bit a[i]&b[j] belongs to column i+j; within a column the
    // dots are stacked by ascending j, the k-th dot going to row k at position column-k.
    function automatic logic [63:0] ref_dots(input logic [7:0] av, input logic [7:0] bv);
        logic [14:0] row [8];
        logic [63:0] flat;
        int          k;
        int          pos;
        for (int r = 0; r < 8; r++) row[r] = '0;
        for (int c = 0; c < 15; c++) begin
            k = 0;
            for (int j = 0; j < 8; j++) begin
                if (c - j >= 0 && c - j <= 7) begin
                    row[k][c - k] = av[c - j] & bv[j];
                    k++;
                end
            end
        end
        flat = '0;
        pos  = 0;
        for (int r = 0; r < 8; r++) begin
            for (int t = 0; t < 15 - 2 * r; t++) begin
                flat[pos] = row[r][t];
                pos++;
            end
        end
        return flat;
    endfunction

    always @(negedge clk) begin : monitor
        if (!rst) begin
            check("in_ready", bus.in_ready, m_cnt < DEPTH);
            check("pp_valid", bus.pp_valid, m_valid);
            check("ops_count", ops_count, m_ops);
            if (bus.pp_valid) begin
                check("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check("pp_rows", act_dots, exp_q[0]);
                    if (bus.pp_ready) last_exp = exp_q.pop_front();
                end
            end else begin
`ifdef PP_GEN_HOLD_EN
                idle_exp = last_exp;
`else
                idle_exp = '0;
`endif
                check("pp_idle", act_dots, idle_exp);
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_dots(bus.a, bus.b));
            m_push = bus.in_valid && (m_cnt < DEPTH);
            m_load = (m_cnt > 0) && (!m_valid || bus.pp_ready);
            if (m_push && m_ops < OPS_MAX) m_ops++;
            m_cnt = m_cnt + int'(m_push) - int'(m_load);
            if (m_load) m_valid = 1'b1;
            else if (bus.pp_ready) m_valid = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] av, input logic [7:0] bv);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        if (!bus.in_ready) check("send_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Asserts rst between edges and checks the asynchronous clear before any clock arrives.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_pp_valid", bus.pp_valid, 1'b0);
        check("rst_ops_count", ops_count, '0);
        check("rst_pp_bits", act_dots, '0);
        exp_q.delete();
        m_cnt    = 0;
        m_valid  = 1'b0;
        m_ops    = 0;
        last_exp = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.pp_ready = 1'b0;
        do_reset();

        bus.pp_ready = 1'b1;
        send(8'h80, 8'h01);
        idle(3);
        send(8'h01, 8'h80);
        send(8'hFF, 8'hFF);
        idle(3);

        bus.pp_ready = 1'b0;
        send(8'd1, 8'd1);
        send(8'd2, 8'd3);
        send(8'd4, 8'd5);
        idle(4);
        bus.pp_ready = 1'b1;
        idle(5);

        repeat (300) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            bus.pp_ready = ($urandom_range(0, 9) < 6);
            idle(1);
        end

        bus.in_valid = 1'b0;
        bus.pp_ready = 1'b1;
        idle(4);
        bus.pp_ready = 1'b0;
        send(8'h11, 8'h22);
        send(8'h33, 8'h44);
        send(8'h55, 8'h66);
        do_reset();
        bus.pp_ready = 1'b1;
        send(8'h5A, 8'hC3);
        idle(5);

        bus.in_valid = 1'b0;
        bus.pp_ready = 1'b1;
        idle(10);
        check("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
